key_event_device: RTL
=====================

KEY_EVENT_DEVICE -- requirements
Module: key_event_device

Interface
REQ-001 SHALL have parameter BITS, default 32: data/address bus width; legal range 32 and up.
REQ-002 SHALL have parameter BASE, default 32'hF0000010: data register address; the control/status register is at BASE+32'h100.
REQ-003 SHALL have parameter NKEYS, default 4: number of key inputs; legal range 1..16.
REQ-004 SHALL have parameter DEPTH, default 4: event FIFO depth; power of 2, legal range 2..128.
REQ-005 SHALL have parameter DBCYCLES, default 16: debounce stability window in clocks; minimum 1.
REQ-006 SHALL have port CLK, input, 1 bit: sole clock; all state changes on posedge.
REQ-007 SHALL have port LOCK, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port ABUS, input, BITS bits: address.
REQ-009 SHALL have port DBUS, inout, BITS bits: data; driven only on a selected read, else high-Z.
REQ-010 SHALL have port WE, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port FLUSH, input, 1 bit: pipeline flush; while 1, no register is selected.
REQ-012 SHALL have port KEY, input, NKEYS bits: raw asynchronous key levels.
REQ-013 SHALL have port INTR, output, 1 bit: interrupt request.

Function
REQ-014 SHALL pass KEY through a 2-flop synchronizer; SYNC is the second-stage value.
REQ-015 SHALL track CAND (candidate) and CNT (debounce counter) as follows:
- SYNC != CAND: CAND <= SYNC and CNT <= 0.
- Otherwise: CNT increments, saturating at DBCYCLES-1.
REQ-016 SHALL, when SYNC == CAND, CNT == DBCYCLES-1 and CAND != STABLE: set STABLE <= CAND and raise a one-cycle event that pushes CAND into the FIFO.
REQ-017 SHALL drop the pushed value and set OR (overrun) when a push arrives while the FIFO is full and no pop occurs in the same cycle.
REQ-018 SHALL accept a push and a pop in the same cycle, full case included; occupancy stays unchanged and OR is not set.
REQ-019 SHALL define the data read as ABUS==BASE && !WE && !FLUSH. It SHALL:
- drive DBUS with the FIFO head, zero-extended, in the same cycle (combinational);
- pop at the next posedge when the FIFO is non-empty.
REQ-020 SHALL, on a data read with the FIFO empty, drive STABLE zero-extended and perform no pop.
REQ-021 SHALL ignore writes to BASE.
REQ-022 SHALL define the control read as ABUS==BASE+32'h100 && !WE && !FLUSH, driving:
- bit 0: RE (FIFO non-empty);
- bit 2: OR;
- bit 8: IE;
- bits 23:16: occupancy, 0..DEPTH;
- all other bits 0.
REQ-023 SHALL define the control write as ABUS==BASE+32'h100 && WE && !FLUSH. It SHALL:
- set IE <= DBUS[8];
- clear OR if DBUS[2]==0; DBUS[2]==1 leaves OR unchanged.
REQ-024 SHALL give a same-cycle overrun priority over an OR-clearing write (OR ends at 1).
REQ-025 SHALL drive INTR = IE && (RE || OR), combinationally from registered state.
REQ-026 SHALL wrap FIFO pointers modulo DEPTH; occupancy width is clog2(DEPTH)+1.
REQ-027 SHALL, while FLUSH=1, not drive DBUS and change no register state, except that debounce and event pushes continue.

Reset
REQ-028 SHALL, while LOCK=0, hold the following at 0: synchronizer, CAND, CNT, STABLE, FIFO pointers, occupancy, IE and OR.
REQ-029 SHALL, during reset, hold INTR=0 and DBUS at high-Z.
REQ-030 SHALL discard all FIFO contents when LOCK is asserted mid-operation.
REQ-031 SHALL resume operation on the first posedge after LOCK rises. A non-zero KEY held through reset SHALL produce one event after synchronizer plus debounce latency.

Verification
REQ-032 Debounce latency (NKEYS=4, DBCYCLES=16): KEY 0->4'h5 held steady -> one push of 4'h5 within 2+16+1 clocks; STABLE=4'h5; control read = 32'h0001_0001.
REQ-033 Bounce rejection: KEY toggling with period <16 clocks, then settling at 4'h3 -> exactly one event, 4'h3, no intermediate values pushed.
REQ-034 Overrun: with DEPTH=4, 5 distinct stable changes and no reads -> occupancy 4, OR=1, first 4 values read back in order; write 32'h100 clears OR, IE=1.
REQ-035 Interrupt: write IE=1, then generate 1 event -> INTR=1; data read returns the value; after the pop INTR=0. IE=0 with events pending -> INTR=0.
REQ-036 Simultaneous push and pop, FIFO full: push and data read in the same cycle -> occupancy stays 4, OR stays 0, FIFO order preserved.
REQ-037 Reset mid-run: LOCK low with 3 events queued -> occupancy 0, IE=OR=0, INTR=0 immediately (no clock needed); empty data read returns STABLE=0.

Source files
------------

// File: rtl/key_event_device.sv
// Debounced key-event capture with a small event FIFO behind a two-register
// memory-mapped port: data (FIFO head / stable level) and control/status.
module key_event_device #(
    parameter int          BITS     = 32,
    parameter logic [31:0] BASE     = 32'hF0000010,
    parameter int          NKEYS    = 4,
    parameter int          DEPTH    = 4,
    parameter int          DBCYCLES = 16
) (
    input  logic             CLK,
    input  logic             LOCK,
    input  logic [BITS-1:0]  ABUS,
    inout  wire  [BITS-1:0]  DBUS,
    input  logic             WE,
    input  logic             FLUSH,
    input  logic [NKEYS-1:0] KEY,
    output logic             INTR
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = (DBCYCLES > 1) ? $clog2(DBCYCLES) : 1;

    localparam logic [BITS-1:0] DATA_ADDR = BITS'(BASE);
    localparam logic [BITS-1:0] CTRL_ADDR = BITS'(BASE + 32'h100);
    localparam logic [CW-1:0]   CNT_MAX   = CW'(DBCYCLES - 1);
    localparam logic [OW-1:0]   OCC_FULL  = OW'(DEPTH);

    logic [NKEYS-1:0] sync1, sync2;
    logic [NKEYS-1:0] cand, stable;
    logic [CW-1:0]    cnt;
    logic             evt;

    logic [NKEYS-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [OW-1:0]    occ;
    logic             ie, or_flag;

    logic             re, full;
    logic             data_rd, ctrl_rd, ctrl_wr;
    logic             pop, push_ok, overrun;
    logic [BITS-1:0]  rd_data;

    // A new level is reported once it has held for the full window and differs
    // from the last reported level.
    assign evt = (sync2 == cand) && (cnt == CNT_MAX) && (cand != stable);

    always_ff @(posedge CLK or negedge LOCK) begin
        if (!LOCK) begin
            sync1  <= '0;
            sync2  <= '0;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            if (evt) begin
                stable <= cand;
            end
        end
    end

    assign re      = (occ != '0);
    assign full    = (occ == OCC_FULL);
    assign data_rd = (ABUS == DATA_ADDR) && !WE && !FLUSH;
    assign ctrl_rd = (ABUS == CTRL_ADDR) && !WE && !FLUSH;
    assign ctrl_wr = (ABUS == CTRL_ADDR) && WE && !FLUSH;
    assign pop     = data_rd && re;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign push_ok = evt && (!full || pop);
    assign overrun = evt && full && !pop;

    always_ff @(posedge CLK or negedge LOCK) begin
        if (!LOCK) begin
            wptr    <= '0;
            rptr    <= '0;
            occ     <= '0;
            ie      <= 1'b0;
            or_flag <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push_ok && !pop) begin
                occ <= occ + OW'(1);
            end else if (pop && !push_ok) begin
                occ <= occ - OW'(1);
            end
            if (ctrl_wr) begin
                ie <= DBUS[8];
            end
            // Overrun wins over a clearing write in the same cycle.
            if (overrun) begin
                or_flag <= 1'b1;
            end else if (ctrl_wr && !DBUS[2]) begin
                or_flag <= 1'b0;
            end
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wptr] <= cand;
        end
    end

    always_comb begin
        rd_data = '0;
        if (data_rd) begin
            rd_data[NKEYS-1:0] = re ? mem[rptr] : stable;
        end else begin
            rd_data[0]        = re;
            rd_data[2]        = or_flag;
            rd_data[8]        = ie;
            rd_data[16 +: OW] = occ;
        end
    end

    assign DBUS = (LOCK && (data_rd || ctrl_rd)) ? rd_data : {BITS{1'bz}};
    assign INTR = ie && (re || or_flag);

endmodule
